arcade_input_mapper: RTL and testbench

ARCADE_INPUT_MAPPER -- requirements
Module: arcade_input_mapper

---
 rtl/arcade_input_mapper.sv | 188 ++++++++++++++++++
 tb/tb_arcade_input_mapper.sv | 218 +++++++++++++++++++++
 2 files changed

// File: rtl/arcade_input_mapper.sv
`default_nettype none
// ============================================================================
// Module      : arcade_input_mapper
// Description : Merges PS/2 keyboard and joysticks into rotated, SOCD-cleaned
//               player controls, with timed coin pulses per coin channel.
// Revision    : 1.0 - initial release
// ============================================================================
module arcade_input_mapper #(
    parameter int NUM_BTN    = 2,
    parameter int COIN_PULSE = 200000,
    parameter int COIN_GAP   = 200000
) (
    input  logic               clk_sys,
    input  logic               RESET,
    input  logic [64:0]        ps2_key,
    input  logic [15:0]        joystick_0,
    input  logic [15:0]        joystick_1,
    input  logic [1:0]         rotate,
    input  logic               coin_on_start,
    output logic [3:0]         p1_dir,
    output logic [3:0]         p2_dir,
    output logic [NUM_BTN-1:0] p1_btn,
    output logic [NUM_BTN-1:0] p2_btn,
    output logic [1:0]         start,
    output logic [1:0]         coin
);

    localparam int MAX_CNT = (COIN_PULSE > COIN_GAP) ? COIN_PULSE : COIN_GAP;
    localparam int CNT_W   = $clog2(MAX_CNT + 1);

    // Key-state bit layout; bits 3:0 line up with the joystick direction bits.
    localparam int K_RIGHT  = 0;
    localparam int K_LEFT   = 1;
    localparam int K_DOWN   = 2;
    localparam int K_UP     = 3;
    localparam int K_FIRE0  = 4;
    localparam int K_START1 = 8;
    localparam int K_START2 = 9;
    localparam int K_COIN1  = 10;
    localparam int K_COIN2  = 11;

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_PULSE = 2'd1,
        S_GAP   = 2'd2
    } coin_state_t;

    logic               tgl_q;
    logic [11:0]        key_q, key_d;
    logic [3:0]         p1_dir_q, p1_dir_d, p2_dir_q, p2_dir_d;
    logic [NUM_BTN-1:0] p1_btn_q, p1_btn_d, p2_btn_q, p2_btn_d;
    logic [1:0]         start_q, start_d;
    logic [1:0]         coin_src;
    logic               ps2_evt, pressed, extended;

    function automatic logic [3:0] map_dir(input logic [3:0] raw, input logic [1:0] rot);
        logic [3:0] o;
        case (rot)
            2'd0:    o = raw;
            2'd1:    o = {raw[1], raw[0], raw[2], raw[3]};
            2'd2:    o = {raw[2], raw[3], raw[0], raw[1]};
            default: o = {raw[0], raw[1], raw[3], raw[2]};
        endcase
        if (o[3] && o[2]) o[3:2] = 2'b00;
        if (o[1] && o[0]) o[1:0] = 2'b00;
        return o;
    endfunction

    always_comb begin
        pressed  = (ps2_key[15:8] != 8'hF0);
        extended = pressed ? (ps2_key[15:8] == 8'hE0) : (ps2_key[23:16] == 8'hE0);
        ps2_evt  = (ps2_key[64] != tgl_q);
        key_d    = key_q;
        if (ps2_evt && (ps2_key[63:24] == 40'd0)) begin
            // Arrow codes ignore the E0 prefix so keypad arrows also steer.
            case (ps2_key[7:0])
                8'h75: key_d[K_UP]    = pressed;
                8'h72: key_d[K_DOWN]  = pressed;
                8'h6B: key_d[K_LEFT]  = pressed;
                8'h74: key_d[K_RIGHT] = pressed;
                8'h29, 8'h14: if (!extended) key_d[K_FIRE0] = pressed;
                8'h11: if (!extended && NUM_BTN > 1) key_d[K_FIRE0+1] = pressed;
                8'h12: if (!extended && NUM_BTN > 2) key_d[K_FIRE0+2] = pressed;
                8'h1A: if (!extended && NUM_BTN > 3) key_d[K_FIRE0+3] = pressed;
                8'h05: if (!extended) key_d[K_START1] = pressed;
                8'h06: if (!extended) key_d[K_START2] = pressed;
                8'h2E: if (!extended) key_d[K_COIN1]  = pressed;
                8'h36: if (!extended) key_d[K_COIN2]  = pressed;
                default: ;
            endcase
        end
    end

    always_comb begin
        p1_dir_d = map_dir(key_q[3:0] | joystick_0[3:0], rotate);
        p2_dir_d = map_dir(joystick_1[3:0], rotate);
        for (int i = 0; i < NUM_BTN; i++) begin
            p1_btn_d[i] = key_q[K_FIRE0+i] | joystick_0[4+i];
            p2_btn_d[i] = joystick_1[4+i];
        end
        start_d     = {key_q[K_START2] | joystick_1[4+NUM_BTN],
                       key_q[K_START1] | joystick_0[4+NUM_BTN]};
        coin_src[0] = key_q[K_COIN1] | joystick_0[5+NUM_BTN] | (coin_on_start & (|start_d));
        coin_src[1] = key_q[K_COIN2] | joystick_1[5+NUM_BTN];
    end

    always_ff @(posedge clk_sys) begin
        // Track the toggle even in reset so no stale event fires afterwards.
        tgl_q <= ps2_key[64];
        if (RESET) begin
            key_q    <= '0;
            p1_dir_q <= '0;
            p2_dir_q <= '0;
            p1_btn_q <= '0;
            p2_btn_q <= '0;
            start_q  <= '0;
        end else begin
            key_q    <= key_d;
            p1_dir_q <= p1_dir_d;
            p2_dir_q <= p2_dir_d;
            p1_btn_q <= p1_btn_d;
            p2_btn_q <= p2_btn_d;
            start_q  <= start_d;
        end
    end

    assign p1_dir = p1_dir_q;
    assign p2_dir = p2_dir_q;
    assign p1_btn = p1_btn_q;
    assign p2_btn = p2_btn_q;
    assign start  = start_q;

    generate
        for (genvar ch = 0; ch < 2; ch++) begin : g_coin
            coin_state_t      state_q, state_d;
            logic [CNT_W-1:0] cnt_q, cnt_d;
            logic             src_prev_q;
            logic             src_rise;

            assign src_rise = coin_src[ch] & ~src_prev_q;

            // History loads the live source during reset, so a held source never edges.
            always_ff @(posedge clk_sys) begin
                src_prev_q <= coin_src[ch];
                if (RESET) begin
                    state_q <= S_IDLE;
                    cnt_q   <= '0;
                end else begin
                    state_q <= state_d;
                    cnt_q   <= cnt_d;
                end
            end

            always_comb begin
                state_d = state_q;
                cnt_d   = cnt_q;
                case (state_q)
                    S_IDLE: begin
                        if (src_rise) begin
                            state_d = S_PULSE;
                            cnt_d   = CNT_W'(COIN_PULSE - 1);
                        end
                    end
                    S_PULSE: begin
                        if (cnt_q == '0) begin
                            state_d = S_GAP;
                            cnt_d   = CNT_W'(COIN_GAP - 1);
                        end else begin
                            cnt_d = cnt_q - CNT_W'(1);
                        end
                    end
                    S_GAP: begin
                        if (cnt_q == '0) state_d = S_IDLE;
                        else             cnt_d   = cnt_q - CNT_W'(1);
                    end
                    default: state_d = S_IDLE;
                endcase
            end

            assign coin[ch] = (state_q == S_PULSE);
        end
    endgenerate

    logic unused_ok;
    assign unused_ok = ^{joystick_0[15:6+NUM_BTN], joystick_1[15:6+NUM_BTN], key_q[7:4]};

endmodule
`default_nettype wire

// File: tb/tb_arcade_input_mapper.sv
`default_nettype none
// ============================================================================
// Module      : tb_arcade_input_mapper
// Description : Scoreboard bench for arcade_input_mapper (levels and coin pulses).
// Revision    : 1.0 - initial release
// ============================================================================
module tb_arcade_input_mapper;

    localparam int NB = 2;
    localparam int CP = 4;
    localparam int CG = 3;
    localparam logic [15:0] NC  = 16'h3FFF;
    localparam logic [15:0] ALL = 16'hFFFF;

    logic        clk = 1'b0;
    logic        rst;
    logic [64:0] ps2_key;
    logic [15:0] joystick_0, joystick_1;
    logic [1:0]  rotate;
    logic        coin_on_start;
    logic [3:0]  p1_dir, p2_dir;
    logic [NB-1:0] p1_btn, p2_btn;
    logic [1:0]  start, coin;

    arcade_input_mapper #(.NUM_BTN(NB), .COIN_PULSE(CP), .COIN_GAP(CG)) dut (
        .clk_sys(clk), .RESET(rst), .ps2_key(ps2_key),
        .joystick_0(joystick_0), .joystick_1(joystick_1), .rotate(rotate),
        .coin_on_start(coin_on_start), .p1_dir(p1_dir), .p2_dir(p2_dir),
        .p1_btn(p1_btn), .p2_btn(p2_btn), .start(start), .coin(coin)
    );

    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    typedef struct {
        int          due;
        logic [15:0] exp;
        logic [15:0] mask;
        string       nm;
    } lchk_t;

    lchk_t lq[$];
    int    cq0[$];
    int    cq1[$];
    int    n_cmp = 0;
    int    n_fail = 0;
    int    run0 = 0;
    int    run1 = 0;
    logic  done = 1'b0;
    lchk_t mc;

    logic [15:0] obs;
    assign obs = {coin, start, p2_btn, p1_btn, p2_dir, p1_dir};

    function automatic logic [15:0] mk(input logic [3:0] d1, input logic [3:0] d2,
                                       input logic [1:0] b1, input logic [1:0] b2,
                                       input logic [1:0] st, input logic [1:0] cn);
        return {cn, st, b2, b1, d2, d1};
    endfunction

    // Expected value 0 marks a pulse cut short by reset: any length below CP.
    task automatic pulse_end(input int ch, input int len);
        int e;
        n_cmp++;
        if ((ch == 0 && cq0.size() == 0) || (ch == 1 && cq1.size() == 0)) begin
            n_fail++;
            $display("FAIL coin%0d_unexpected: got pulse of %0d cycles, required none", ch, len);
        end else begin
            e = (ch == 0) ? cq0.pop_front() : cq1.pop_front();
            if ((e == 0 && (len < 1 || len >= CP)) || (e != 0 && len != e)) begin
                n_fail++;
                $display("FAIL coin%0d_len: got %0d cycles, required %0d (0=truncated)", ch, len, e);
            end
        end
    endtask

    always @(negedge clk) begin
        if (lq.size() > 0 && lq[0].due <= cyc) begin
            mc = lq.pop_front();
            n_cmp++;
            if (mc.due != cyc) begin
                n_fail++;
                $display("FAIL %s: missed sample at cycle %0d, required cycle %0d", mc.nm, cyc, mc.due);
            end else if ((obs & mc.mask) != (mc.exp & mc.mask)) begin
                n_fail++;
                $display("FAIL %s: got %h, required %h (mask %h)", mc.nm, obs, mc.exp, mc.mask);
            end
        end
        if (coin[0]) run0++;
        else if (run0 > 0) begin pulse_end(0, run0); run0 = 0; end
        if (coin[1]) run1++;
        else if (run1 > 0) begin pulse_end(1, run1); run1 = 0; end
        if (done) begin
            n_cmp += 3;
            if (lq.size() != 0) begin
                n_fail++;
                $display("FAIL level_queue: got %0d pending, required 0", lq.size());
            end
            if (cq0.size() != 0 || run0 != 0) begin
                n_fail++;
                $display("FAIL coin0_missing: got %0d pending/run %0d, required 0", cq0.size(), run0);
            end
            if (cq1.size() != 0 || run1 != 0) begin
                n_fail++;
                $display("FAIL coin1_missing: got %0d pending/run %0d, required 0", cq1.size(), run1);
            end
            $display("== %0d vectors applied, %0d miscompares ==", n_cmp, n_fail);
            $finish;
        end
    end

    initial begin
        #500000;
        $display("FAIL watchdog: simulation did not complete, required completion");
        $fatal(1, "watchdog");
    end

    task automatic tick(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic chk(input string nm, input int lat, input logic [15:0] e, input logic [15:0] m);
        lq.push_back('{cyc + lat, e, m, nm});
    endtask

    task automatic kbd(input logic [63:0] code);
        ps2_key = {~ps2_key[64], code};
    endtask

    initial begin
        rst = 1'b1; ps2_key = '0; joystick_0 = '0; joystick_1 = '0;
        rotate = 2'd0; coin_on_start = 1'b0;
        tick(3);
        chk("reset", 1, '0, ALL);
        ps2_key = {1'b1, 64'h00E075};
        tick(2);
        rst = 1'b0;
        chk("no_evt_after_rst", 2, '0, NC); tick(3);

        // Keyboard directions, extended and keypad
        kbd(64'h00E075); chk("kbd_up", 2, mk(4'b1000, 0, 0, 0, 0, 0), NC); tick(3);
        kbd(64'hE0F075); chk("kbd_up_rel", 2, '0, NC); tick(3);
        kbd(64'h000075); chk("kp_up", 2, mk(4'b1000, 0, 0, 0, 0, 0), NC); tick(3);
        kbd(64'h00F075); chk("kp_up_rel", 2, '0, NC); tick(3);
        kbd(64'h00E06B); chk("kbd_left", 2, mk(4'b0010, 0, 0, 0, 0, 0), NC); tick(3);
        kbd(64'h000074); chk("socd_lr", 2, '0, NC); tick(3);
        kbd(64'h00F074); chk("socd_lr_rel", 2, mk(4'b0010, 0, 0, 0, 0, 0), NC); tick(3);
        kbd(64'hE0F06B); chk("left_rel", 2, '0, NC); tick(3);

        // Fire keys, extended/long codes ignored, fire2 beyond NUM_BTN ignored
        kbd(64'h00E029); chk("ext_space_ign", 2, '0, NC); tick(3);
        kbd(64'hE0F029); tick(3);
        kbd({40'h1, 24'h000029}); chk("long_code_ign", 2, '0, NC); tick(3);
        kbd(64'h000029); chk("space_fire0", 2, mk(0, 0, 2'b01, 0, 0, 0), NC); tick(3);
        kbd(64'h000011); chk("alt_fire1", 2, mk(0, 0, 2'b11, 0, 0, 0), NC); tick(3);
        kbd(64'h000012); chk("fire2_ign", 2, mk(0, 0, 2'b11, 0, 0, 0), NC); tick(3);
        kbd(64'h00F029); chk("space_rel", 2, mk(0, 0, 2'b10, 0, 0, 0), NC); tick(3);
        kbd(64'h00F011); chk("alt_rel", 2, '0, NC); tick(3);
        kbd(64'h00F012); tick(3);
        kbd(64'h000005); chk("f1_start1", 2, mk(0, 0, 0, 0, 2'b01, 0), NC); tick(3);
        kbd(64'h00F005); chk("f1_rel", 2, '0, NC); tick(3);

        // Joystick rotation and SOCD
        joystick_0 = 16'h0008; rotate = 2'd1; chk("rot1", 1, mk(4'b0001, 0, 0, 0, 0, 0), NC); tick(2);
        rotate = 2'd2; chk("rot2", 1, mk(4'b0100, 0, 0, 0, 0, 0), NC); tick(2);
        rotate = 2'd3; chk("rot3", 1, mk(4'b0010, 0, 0, 0, 0, 0), NC); tick(2);
        rotate = 2'd0; chk("rot0", 1, mk(4'b1000, 0, 0, 0, 0, 0), NC); tick(2);
        joystick_0 = 16'h000C; chk("socd_ud", 1, '0, NC); tick(2);
        joystick_0 = 16'h0009; chk("up_right", 1, mk(4'b1001, 0, 0, 0, 0, 0), NC); tick(2);
        joystick_0 = 16'h0003; chk("socd_lr_joy", 1, '0, NC); tick(2);
        joystick_0 = 16'h000C; rotate = 2'd1; chk("socd_after_rot", 1, '0, NC); tick(2);
        joystick_0 = 16'h0000; rotate = 2'd0;
        joystick_1 = 16'h0076; chk("p2_all", 1, mk(0, 4'b0110, 0, 2'b11, 2'b10, 0), NC); tick(2);
        rotate = 2'd3; chk("p2_rot3", 1, mk(0, 4'b0101, 0, 2'b11, 2'b10, 0), NC); tick(2);
        joystick_1 = 16'h0000; rotate = 2'd0;
        joystick_0 = 16'h0010; chk("joy_fire0", 1, mk(0, 0, 2'b01, 0, 0, 0), NC); tick(2);
        kbd(64'h000029); chk("or_fire0", 2, mk(0, 0, 2'b01, 0, 0, 0), NC); tick(3);
        kbd(64'h00F029); chk("or_key_rel", 2, mk(0, 0, 2'b01, 0, 0, 0), NC); tick(3);
        joystick_0 = 16'h0000; chk("joy_rel", 1, '0, NC); tick(3);

        // Coin key: pulse, re-press inside pulse/gap dropped, later press accepted
        kbd(64'h00002E); cq0.push_back(CP); tick(2);
        kbd(64'h00F02E); tick(3);
        kbd(64'h00002E); tick(2);
        kbd(64'h00F02E); tick(8);
        kbd(64'h00002E); cq0.push_back(CP); tick(2);
        kbd(64'h00F02E); tick(12);
        kbd(64'h000036); cq1.push_back(CP); tick(2);
        kbd(64'h00F036); tick(12);
        joystick_0 = 16'h0080; cq0.push_back(CP); tick(14);
        joystick_0 = 16'h0000; tick(3);

        // Coin on start
        coin_on_start = 1'b1;
        kbd(64'h000006); cq0.push_back(CP); chk("f2_start2_coin", 2, mk(0, 0, 0, 0, 2'b10, 0), NC); tick(3);
        kbd(64'h00F006); chk("f2_rel", 2, '0, NC); tick(12);
        coin_on_start = 1'b0;
        kbd(64'h000006); chk("f2_no_coin", 2, mk(0, 0, 0, 0, 2'b10, 0), NC); tick(3);
        kbd(64'h00F006); tick(12);

        // Reset mid-pulse with the source held
        joystick_0 = 16'h0080; cq0.push_back(0); tick(2);
        chk("coin_pre_rst", 0, mk(0, 0, 0, 0, 0, 2'b01), ALL);
        rst = 1'b1; chk("coin_rst_drop", 1, '0, ALL); tick(3);
        rst = 1'b0; tick(10);
        chk("no_retrig_held", 0, '0, ALL);
        joystick_0 = 16'h0000; tick(3);
        joystick_0 = 16'h0080; cq0.push_back(CP); tick(10);
        joystick_0 = 16'h0000; tick(5);

        done = 1'b1;
    end

endmodule
`default_nettype wire
